// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request, a circular
// instruction queue toward decode, and redirect flush with stale-response drop.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_W-1:0]       out_pc_plus4,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pcp4;
  } entry_t;

  entry_t            r_q [DEPTH];
  logic [ADDR_W-1:0] r_fetch_pc, r_req_pc;
  logic              r_out, r_stale;
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic w_hs, w_rsp, w_push, w_pop;

  // Gating with reset keeps the request low while reset is held, and lets the
  // first request appear as soon as reset releases.
  assign imem_req  = reset & ~r_out & (r_count < CW'(DEPTH)) & ~redirect_valid;
  assign imem_addr = r_fetch_pc;
  assign w_hs      = imem_req & imem_ready;
  assign w_rsp     = imem_rvalid & r_out;
  assign w_push    = w_rsp & ~r_stale & ~redirect_valid;
  assign w_pop     = out_valid & out_ready & ~redirect_valid;

  assign out_valid    = (r_count != '0);
  assign out_instr    = r_q[r_rd_ptr].instr;
  assign out_pc_plus4 = r_q[r_rd_ptr].pcp4;
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= '{instr: imem_rdata, pcp4: r_req_pc + ADDR_W'(4)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC & ~ADDR_W'(3);
      r_req_pc   <= '0;
      r_out      <= 1'b0;
      r_stale    <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_count    <= '0;
      r_rd_ptr   <= r_wr_ptr;
      r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
      // An in-flight response either lands now (drop it) or later (mark stale).
      if (r_out) begin
        if (imem_rvalid) begin
          r_out   <= 1'b0;
          r_stale <= 1'b0;
        end else begin
          r_stale <= 1'b1;
        end
      end
    end else begin
      if (w_rsp) begin
        r_out   <= 1'b0;
        r_stale <= 1'b0;
      end
      if (w_hs) begin
        r_out      <= 1'b1;
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed cycle-by-cycle vectors for fetch_queue with hand-computed outputs,
// plus reset-abandon, push/pop overlap and back-to-back redirect sequences.
module tb_fetch_queue;
  logic        clk, reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc_plus4;
  logic        redirect_valid, out_valid, out_ready;
  logic [2:0]  count;

  fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_instr, e_pc4;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic ordy, logic e_req, logic [31:0] e_addr,
                              logic e_ov, logic [31:0] e_instr, logic [31:0] e_pc4, logic [2:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.ordy = ordy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_instr = e_instr;
    v.e_pc4 = e_pc4; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then step past the edge.
  task automatic cyc(vec_t v, int idx);
    imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rdata;
    redirect_valid = v.redir; redirect_pc = v.rpc; out_ready = v.ordy;
    #2;
    chk("imem_req",  idx, 32'(imem_req),  32'(v.e_req));
    chk("imem_addr", idx, imem_addr,      v.e_addr);
    chk("out_valid", idx, 32'(out_valid), 32'(v.e_ov));
    chk("count",     idx, 32'(count),     32'(v.e_cnt));
    if (v.e_ov) begin
      chk("out_instr",    idx, out_instr,    v.e_instr);
      chk("out_pc_plus4", idx, out_pc_plus4, v.e_pc4);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    //          rdy rv rdata         rd rpc           ordy req addr          ov instr         pc4           cnt
    // steady 1-cycle memory, one instruction per two cycles
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h0,        0,32'h0,        32'h0,        0)); // 0
    tbl.push_back(mk(1,1,32'hA0,       0,32'h0,        1, 0,32'h4,        0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h4,        1,32'hA0,       32'h4,        1));
    tbl.push_back(mk(1,1,32'hA1,       0,32'h0,        1, 0,32'h8,        0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h8,        1,32'hA1,       32'h8,        1));
    tbl.push_back(mk(1,1,32'hA2,       0,32'h0,        1, 0,32'hC,        0,32'h0,        32'h0,        0)); // 5
    // decode stalled: fill to DEPTH, request stops, spurious rvalid ignored
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 1,32'hC,        1,32'hA2,       32'hC,        1));
    tbl.push_back(mk(1,1,32'hA3,       0,32'h0,        0, 0,32'h10,       1,32'hA2,       32'hC,        1));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 1,32'h10,       1,32'hA2,       32'hC,        2));
    tbl.push_back(mk(1,1,32'hA4,       0,32'h0,        0, 0,32'h14,       1,32'hA2,       32'hC,        2));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 1,32'h14,       1,32'hA2,       32'hC,        3)); // 10
    tbl.push_back(mk(1,1,32'hA5,       0,32'h0,        0, 0,32'h18,       1,32'hA2,       32'hC,        3));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 0,32'h18,       1,32'hA2,       32'hC,        4));
    tbl.push_back(mk(1,1,32'hDEAD,     0,32'h0,        0, 0,32'h18,       1,32'hA2,       32'hC,        4));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 0,32'h18,       1,32'hA2,       32'hC,        4));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 1,32'h18,       1,32'hA3,       32'h10,       3)); // 15
    // redirect to 0x103 with count=3 and request outstanding
    tbl.push_back(mk(1,0,32'h0,        1,32'h103,      0, 0,32'h1C,       1,32'hA3,       32'h10,       3));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 0,32'h100,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,1,32'hBAD0,     0,32'h0,        0, 0,32'h100,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h100,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,1,32'hB0,       0,32'h0,        1, 0,32'h104,      0,32'h0,        32'h0,        0)); // 20
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        0, 1,32'h104,      1,32'hB0,       32'h104,      1));
    // redirect coincident with rvalid and pop
    tbl.push_back(mk(1,1,32'hBAD1,     1,32'h200,      1, 0,32'h108,      1,32'hB0,       32'h104,      1));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h200,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,1,32'hC0,       0,32'h0,        1, 0,32'h204,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h204,      1,32'hC0,       32'h204,      1)); // 25
    // address wrap from 0xFFFFFFFC
    tbl.push_back(mk(1,0,32'h0,        1,32'hFFFFFFFC, 1, 0,32'h208,      0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,1,32'hBAD2,     0,32'h0,        1, 0,32'hFFFFFFFC, 0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'hFFFFFFFC, 0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,1,32'hD0,       0,32'h0,        1, 0,32'h0,        0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h0,        1,32'hD0,       32'h0,        1)); // 30
    tbl.push_back(mk(1,1,32'hD1,       0,32'h0,        1, 0,32'h4,        0,32'h0,        32'h0,        0));
    tbl.push_back(mk(1,0,32'h0,        0,32'h0,        1, 1,32'h4,        1,32'hD1,       32'h4,        1));

    reset = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   -1, 32'(imem_req),  32'h0);
    chk("rst_valid", -1, 32'(out_valid), 32'h0);
    chk("rst_count", -1, 32'(count),     32'h0);
    chk("rst_addr",  -1, imem_addr,      32'h0);
    reset = 1'b1;

    foreach (tbl[i]) cyc(tbl[i], i);

    // Reset while a request is in flight (fetch_pc=8, outstanding) abandons it.
    reset = 1'b0;
    #1;
    chk("midrst_req",   100, 32'(imem_req),  32'h0);
    chk("midrst_valid", 100, 32'(out_valid), 32'h0);
    chk("midrst_count", 100, 32'(count),     32'h0);
    chk("midrst_addr",  100, imem_addr,      32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    // late response right after release must be ignored; first request to RESET_PC
    cyc(mk(0,1,32'hBAD4, 0,32'h0, 1, 1,32'h0,   0,32'h0, 32'h0, 0), 101);
    cyc(mk(1,0,32'h0,    0,32'h0, 1, 1,32'h0,   0,32'h0, 32'h0, 0), 102);
    cyc(mk(1,1,32'hE0,   0,32'h0, 1, 0,32'h4,   0,32'h0, 32'h0, 0), 103);
    // push and pop in the same cycle keep count at 1
    cyc(mk(1,0,32'h0,    0,32'h0, 0, 1,32'h4,   1,32'hE0, 32'h4, 1), 104);
    cyc(mk(1,1,32'hE1,   0,32'h0, 1, 0,32'h8,   1,32'hE0, 32'h4, 1), 105);
    cyc(mk(1,0,32'h0,    0,32'h0, 0, 1,32'h8,   1,32'hE1, 32'h8, 1), 106);
    // back-to-back redirects while outstanding: last wins, stale held
    cyc(mk(1,0,32'h0,    1,32'h300, 0, 0,32'hC,   1,32'hE1, 32'h8, 1), 107);
    cyc(mk(1,0,32'h0,    1,32'h404, 0, 0,32'h300, 0,32'h0, 32'h0, 0), 108);
    cyc(mk(1,0,32'h0,    0,32'h0,   0, 0,32'h404, 0,32'h0, 32'h0, 0), 109);
    cyc(mk(1,1,32'hBAD5, 0,32'h0,   0, 0,32'h404, 0,32'h0, 32'h0, 0), 110);
    cyc(mk(1,0,32'h0,    0,32'h0,   1, 1,32'h404, 0,32'h0, 32'h0, 0), 111);
    cyc(mk(1,1,32'hF0,   0,32'h0,   1, 0,32'h408, 0,32'h0, 32'h0, 0), 112);
    cyc(mk(1,0,32'h0,    0,32'h0,   1, 1,32'h408, 1,32'hF0, 32'h408, 1), 113);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch address and PC width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  ADDR_W  fetch address, bits [1:0] always 0.
REQ-008 imem_ready  input  1  memory accepts request when imem_req & imem_ready.
REQ-009 imem_rvalid  input  1  response data valid.
REQ-010 imem_rdata  input  32  response instruction word.
REQ-011 redirect_valid  input  1  branch/jump taken in decode; flush and refetch.
REQ-012 redirect_pc  input  ADDR_W  new fetch target.
REQ-013 out_valid  output  1  queue head holds a live instruction.
REQ-014 out_ready  input  1  decode not stalled; pop when out_valid & out_ready.
REQ-015 out_instr  output  32  head instruction.
REQ-016 out_pc_plus4  output  ADDR_W  head fetch address + 4.
REQ-017 count  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-018 SHALL keep fetch_pc, outstanding flag, stale flag, circular queue (rd_ptr, wr_ptr, count).
REQ-019 imem_req SHALL be 1 iff outstanding=0, count<DEPTH, redirect_valid=0.
REQ-020 imem_addr SHALL equal fetch_pc.
REQ-021 On request handshake: outstanding<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (modulo 2^ADDR_W).
REQ-022 imem_rvalid with outstanding=0 SHALL be ignored.
REQ-023 imem_rvalid with outstanding=1, stale=0, redirect_valid=0: push {imem_rdata, req_pc+4} at wr_ptr; outstanding<=0.
REQ-024 imem_rvalid with outstanding=1 and stale=1: discard data; outstanding<=0, stale<=0.
REQ-025 No same-cycle issue on response cycle; max throughput one instruction per two cycles for 1-cycle memory.
REQ-026 Latency: handshake at cycle T, rvalid at T+k (k>=1), out_valid earliest T+k+1; no bypass.
REQ-027 out_valid SHALL equal (count!=0); out_instr/out_pc_plus4 driven from rd_ptr entry.
REQ-028 Pop advances rd_ptr by 1 modulo DEPTH; push advances wr_ptr by 1 modulo DEPTH.
REQ-029 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
REQ-030 Push when count=DEPTH cannot occur (REQ-019 credit); pop when count=0 SHALL be ignored.
REQ-031 redirect_valid SHALL take priority over push, pop and issue in the same cycle.
REQ-032 On redirect: count<=0, rd_ptr<=wr_ptr, fetch_pc<={redirect_pc[ADDR_W-1:2],2'b00}.
REQ-033 On redirect with outstanding=1 and no rvalid that cycle: stale<=1; with rvalid that cycle: data dropped, outstanding<=0, stale<=0.
REQ-034 Back-to-back redirects: last one wins; stale stays 1 until the single outstanding response returns.
REQ-035 At most one memory request outstanding at any time.

Reset
REQ-036 While reset=0: fetch_pc=RESET_PC, outstanding=0, stale=0, pointers=0, count=0, out_valid=0, imem_req=0.
REQ-037 Reset assertion mid-request SHALL abandon the request; a late imem_rvalid after release is ignored (outstanding=0).
REQ-038 First request SHALL be driven in the first cycle after reset deasserts (imem_addr=RESET_PC).

Verification
REQ-039 Reset release, imem_ready=1, 1-cycle memory, out_ready=1 -> addresses 0x0,0x4,0x8 every 2 cycles; out_pc_plus4 0x4,0x8,0xC in order.
REQ-040 out_ready=0, DEPTH=4 -> count reaches 4, imem_req drops to 0, no fifth push; out_ready=1 -> pops, fetch resumes.
REQ-041 Redirect to 0x103 while count=3 and request outstanding -> count=0 next cycle, stale response dropped, next imem_addr=0x100.
REQ-042 Redirect coincident with rvalid and pop -> nothing pushed, count=0, stale=0, next request to redirect_pc.
REQ-043 Fetch from 0xFFFFFFFC -> next imem_addr=0x0; out_pc_plus4=0x0.
REQ-044 reset=0 asserted between handshake and rvalid -> all outputs reset immediately; rvalid after release ignored, first request to RESET_PC.
